// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding mux selects and the mult/div tracker states.
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
endpackage

// File: rtl/md_busy_tracker.sv
// Tracks an in-flight multi-cycle mult/div: busy for MD_LAT cycles after a start, done pulse in the last busy cycle.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    output logic md_busy,
    output logic md_done
);
    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 1);

    md_state_t      state;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_start_e) begin
                        state <= MD_BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                MD_BUSY: begin
                    // A restart wins over completion, so no done pulse is produced.
                    if (md_start_e) begin
                        cnt <= CNT_INIT;
                    end else if (cnt == '0) begin
                        state <= MD_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign md_busy = (state == MD_BUSY);
    assign md_done = (state == MD_BUSY) && (cnt == '0) && !md_start_e;
endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: RAW forwarding, load-use/branch/mult-div stalls, jump flush, saturating stall counter.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] wreg_e,
    input  logic [REG_W-1:0] wreg_m,
    input  logic [REG_W-1:0] wreg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             branch_d,
    input  logic             jump_d,
    input  logic             md_start_e,
    input  logic             md_start_d,
    input  logic             md_read_d,
    input  logic             perf_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);
    logic lw_stall, br_stall, md_stall, stall;

    md_busy_tracker #(.MD_LAT(MD_LAT)) u_md (
        .clk        (clk),
        .reset      (reset),
        .md_start_e (md_start_e),
        .md_busy    (md_busy),
        .md_done    (md_done)
    );

    // Register 0 is hardwired, so a zero source index never forwards.
    always_comb begin
        forward_ae = FWD_RF;
        if (rs_e != '0 && regwrite_m && rs_e == wreg_m)      forward_ae = FWD_MEM;
        else if (rs_e != '0 && regwrite_w && rs_e == wreg_w) forward_ae = FWD_WB;

        forward_be = FWD_RF;
        if (rt_e != '0 && regwrite_m && rt_e == wreg_m)      forward_be = FWD_MEM;
        else if (rt_e != '0 && regwrite_w && rt_e == wreg_w) forward_be = FWD_WB;
    end

    assign forward_ad = (rs_d != '0) && regwrite_m && (rs_d == wreg_m);
    assign forward_bd = (rt_d != '0) && regwrite_m && (rt_d == wreg_m);

    assign lw_stall = memtoreg_e && (wreg_e != '0) && (rs_d == wreg_e || rt_d == wreg_e);
    assign br_stall = branch_d &&
        ((regwrite_e && (wreg_e != '0) && (wreg_e == rs_d || wreg_e == rt_d)) ||
         (memtoreg_m && (wreg_m != '0) && (wreg_m == rs_d || wreg_m == rt_d)));
    assign md_stall = (md_read_d || md_start_d) && (md_busy || md_start_e);
    assign stall    = lw_stall || br_stall || md_stall;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall || jump_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (stall && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc with directed scenarios and randomized traffic against a reference model.
module tb_hazard_unit_mc;
    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic branch_d, jump_d, md_start_e, md_start_d, md_read_d, perf_clr;
    logic stall_f, stall_d, flush_e, forward_ad, forward_bd, md_busy, md_done;
    logic [1:0] forward_ae, forward_be;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad = 0;

    // Reference state: remaining busy cycles of the mult/div unit and the stall count.
    int md_left = 0;
    int cnt_m = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
        .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
        .branch_d(branch_d), .jump_d(jump_d),
        .md_start_e(md_start_e), .md_start_d(md_start_d), .md_read_d(md_read_d),
        .perf_clr(perf_clr),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    function automatic logic [1:0] m_fwd_e(input logic [REG_W-1:0] src);
        if (src == 0) return 2'b00;
        if (regwrite_m && wreg_m == src) return 2'b10;
        if (regwrite_w && wreg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_fwd_d(input logic [REG_W-1:0] src);
        return (src != 0) && regwrite_m && (wreg_m == src);
    endfunction

    // True when the named producer register is a nonzero source of the ID instruction.
    function automatic logic reads_in_id(input logic [REG_W-1:0] dst);
        return (dst != 0) && (dst == rs_d || dst == rt_d);
    endfunction

    function automatic logic m_stall();
        logic load_use, branch_dep, md_dep;
        load_use   = memtoreg_e && reads_in_id(wreg_e);
        branch_dep = branch_d && ((regwrite_e && reads_in_id(wreg_e)) ||
                                  (memtoreg_m && reads_in_id(wreg_m)));
        md_dep     = (md_read_d || md_start_d) && (md_left > 0 || md_start_e);
        return load_use || branch_dep || md_dep;
    endfunction

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w} = '0;
        {regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m} = '0;
        {branch_d, jump_d, md_start_e, md_start_d, md_read_d, perf_clr} = '0;
    endtask

    // Advance one clock, updating the reference state from the inputs present at the edge.
    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (perf_clr) cnt_m = 0;
        else if (s && cnt_m < CNT_MAX) cnt_m++;
        if (md_start_e) md_left = MD_LAT;
        else if (md_left > 0) md_left--;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #1;
        total++; if (stall_cycles !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cycles); end
        total++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin bad++; $display("FAIL reset_md got=%b%b want=00", md_busy, md_done); end
        total++; if ({stall_f, flush_e, forward_ae, forward_be} !== 6'b0) begin bad++; $display("FAIL reset_comb got=%b want=0", {stall_f, flush_e, forward_ae, forward_be}); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        md_left = 0; cnt_m = 0;
    endtask

    task automatic test_forward();
        clear_inputs();
        rs_e = 5; wreg_m = 5; regwrite_m = 1; wreg_w = 5; regwrite_w = 1; #1;
        total++; if (forward_ae !== 2'b10) begin bad++; $display("FAIL fwd_mem got=%b want=10", forward_ae); end
        regwrite_m = 0; #1;
        total++; if (forward_ae !== 2'b01) begin bad++; $display("FAIL fwd_wb got=%b want=01", forward_ae); end
        rs_e = 0; #1;
        total++; if (forward_ae !== 2'b00) begin bad++; $display("FAIL fwd_r0 got=%b want=00", forward_ae); end
        rt_e = 7; wreg_m = 7; regwrite_m = 1; wreg_w = 7; #1;
        total++; if (forward_be !== 2'b10) begin bad++; $display("FAIL fwd_be got=%b want=10", forward_be); end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        memtoreg_e = 1; wreg_e = 8; rt_d = 8; #1;
        total++; if ({stall_f, stall_d, flush_e} !== 3'b111) begin bad++; $display("FAIL lw_stall got=%b want=111", {stall_f, stall_d, flush_e}); end
        wreg_e = 0; #1;
        total++; if ({stall_f, stall_d, flush_e} !== 3'b000) begin bad++; $display("FAIL lw_r0 got=%b want=000", {stall_f, stall_d, flush_e}); end
        jump_d = 1; #1;
        total++; if ({stall_f, flush_e} !== 2'b01) begin bad++; $display("FAIL jump_flush got=%b want=01", {stall_f, flush_e}); end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        branch_d = 1; regwrite_e = 1; wreg_e = 3; rs_d = 3; #1;
        total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL br_ex got=%b want=1", stall_f); end
        regwrite_e = 0; wreg_e = 0; memtoreg_m = 1; wreg_m = 3; #1;
        total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL br_mem got=%b want=1", stall_f); end
        memtoreg_m = 0; regwrite_m = 1; #1;
        total++; if (stall_f !== 1'b0 || forward_ad !== 1'b1) begin bad++; $display("FAIL br_fwd got=%b%b want=01", stall_f, forward_ad); end
        tick();
    endtask

    task automatic test_md_sequence();
        clear_inputs();
        md_read_d = 1; md_start_e = 1; #1;
        total++; if (stall_f !== 1'b1 || md_busy !== 1'b0) begin bad++; $display("FAIL md_c0 got=%b%b want=10", stall_f, md_busy); end
        tick();
        md_start_e = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            total++;
            if (md_busy !== (c <= 4) || md_done !== (c == 4) || stall_f !== (c <= 4)) begin
                bad++;
                $display("FAIL md_c%0d busy=%b done=%b stall=%b want=%b%b%b", c, md_busy, md_done, stall_f, c <= 4, c == 4, c <= 4);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        md_start_e = 1; tick();
        md_start_e = 0; tick();
        md_read_d = 1; #1;
        total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", md_busy); end
        reset = 1'b1; #1;
        total++; if (md_busy !== 1'b0 || md_done !== 1'b0 || stall_cycles !== '0) begin bad++; $display("FAIL mid_reset got=%b%b%0d want=000", md_busy, md_done, stall_cycles); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b want=0", stall_f); end
        md_left = 0; cnt_m = 0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; #1;
        total++; if (stall_f !== 1'b0 || md_busy !== 1'b0) begin bad++; $display("FAIL post_reset got=%b%b want=00", stall_f, md_busy); end
        tick();
    endtask

    task automatic test_perf_counter();
        clear_inputs();
        perf_clr = 1; tick(); perf_clr = 0; #1;
        total++; if (stall_cycles !== '0) begin bad++; $display("FAIL perf_clr0 got=%0d want=0", stall_cycles); end
        memtoreg_e = 1; wreg_e = 9; rs_d = 9;
        for (int i = 0; i < 20; i++) tick();
        #1;
        total++; if (stall_cycles !== 4'd15 || cnt_m != 15) begin bad++; $display("FAIL perf_sat got=%0d want=15", stall_cycles); end
        perf_clr = 1; tick(); perf_clr = 0; #1;
        total++; if (stall_cycles !== '0) begin bad++; $display("FAIL perf_clr_stall got=%0d want=0", stall_cycles); end
        tick(); #1;
        total++; if (stall_cycles !== 4'd1) begin bad++; $display("FAIL perf_resume got=%0d want=1", stall_cycles); end
    endtask

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 400; i++) begin
            rs_d = REG_W'($urandom_range(0, 3)); rt_d = REG_W'($urandom_range(0, 3));
            rs_e = REG_W'($urandom_range(0, 3)); rt_e = REG_W'($urandom_range(0, 3));
            wreg_e = REG_W'($urandom_range(0, 3)); wreg_m = REG_W'($urandom_range(0, 3));
            wreg_w = REG_W'($urandom_range(0, 3));
            {regwrite_e, regwrite_m, regwrite_w} = 3'($urandom);
            memtoreg_e = ($urandom_range(0, 3) == 0); memtoreg_m = ($urandom_range(0, 3) == 0);
            branch_d = $urandom_range(0, 1); jump_d = ($urandom_range(0, 3) == 0);
            md_start_e = ($urandom_range(0, 7) == 0);
            md_start_d = ($urandom_range(0, 3) == 0); md_read_d = ($urandom_range(0, 3) == 0);
            perf_clr = ($urandom_range(0, 31) == 0);
            #1;
            exp_stall = m_stall();
            total++;
            if (stall_f !== exp_stall || stall_d !== exp_stall || flush_e !== (exp_stall | jump_d)) begin
                bad++; $display("FAIL rnd_stall i=%0d got=%b%b%b want=%b%b%b", i, stall_f, stall_d, flush_e, exp_stall, exp_stall, exp_stall | jump_d);
            end
            total++;
            if (forward_ae !== m_fwd_e(rs_e) || forward_be !== m_fwd_e(rt_e) ||
                forward_ad !== m_fwd_d(rs_d) || forward_bd !== m_fwd_d(rt_d)) begin
                bad++; $display("FAIL rnd_fwd i=%0d got=%b %b %b %b want=%b %b %b %b", i, forward_ae, forward_be, forward_ad, forward_bd,
                                m_fwd_e(rs_e), m_fwd_e(rt_e), m_fwd_d(rs_d), m_fwd_d(rt_d));
            end
            total++;
            if (md_busy !== (md_left > 0) || md_done !== (md_left == 1 && !md_start_e) || int'(stall_cycles) != cnt_m) begin
                bad++; $display("FAIL rnd_state i=%0d got=%b %b %0d want=%b %b %0d", i, md_busy, md_done, stall_cycles,
                                md_left > 0, md_left == 1 && !md_start_e, cnt_m);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_md_sequence();
        test_reset_mid_busy();
        test_perf_counter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
